// File: rtl/uart_command_serializer.sv
// rtl/uart_command_serializer.sv - byte-by-byte command sender with side terminator (option: UART_CMD_SER_LEN_PREFIX_EN)
module uart_command_serializer #(
  parameter int TIMEOUT = 2000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          soft_reset,
  input  logic [1023:0] input_data,
  input  logic [7:0]    input_data_size,
  input  logic          ble_side,
  input  logic          start,
  input  logic          tx_busy,
  output logic [7:0]    tx_data,
  output logic          tx_start,
  output logic          done,
  output logic          error
);

  localparam int CW = $clog2(TIMEOUT + 2) + 1;
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

`ifdef UART_CMD_SER_LEN_PREFIX_EN
  localparam logic [7:0] PRE = 8'd1;
`else
  localparam logic [7:0] PRE = 8'd0;
`endif

  typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

  state_t         state;
  logic [1023:0]  buf_q;
  logic [7:0]     size_q;
  logic           ble_q;
  logic [7:0]     idx;
  logic [CW-1:0]  cnt;

  logic [7:0]     pay_idx;
  logic [7:0]     term_idx;
  logic [7:0]     cur_byte;
  logic [7:0]     last_idx;
  logic [7:0]     first_byte;
  logic           timed_out;

  // Select the byte for the current index: optional length byte, payload, then terminator.
  always_comb begin
    pay_idx  = idx - PRE;
    term_idx = pay_idx - size_q;
    cur_byte = 8'h00;
`ifdef UART_CMD_SER_LEN_PREFIX_EN
    if (idx == 8'd0)
      cur_byte = size_q;
    else
`endif
    if (pay_idx < size_q)
      cur_byte = buf_q[{pay_idx[6:0], 3'b000} +: 8];
    else if (term_idx == 8'd0)
      cur_byte = ble_q ? 8'h0D : 8'hBE;
    else
      cur_byte = 8'hEF;
  end

  // First byte is taken straight from the inputs so the strobe can follow start by one cycle.
  always_comb begin
`ifdef UART_CMD_SER_LEN_PREFIX_EN
    first_byte = input_data_size;
`else
    if (input_data_size == 8'd0)
      first_byte = ble_side ? 8'h0D : 8'hBE;
    else
      first_byte = input_data[7:0];
`endif
    last_idx  = PRE + size_q + (ble_q ? 8'd0 : 8'd1);
    timed_out = (cnt >= TMO);
  end

  // Command sequencer: latch on start, handshake each byte with the TX core, abort on timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      buf_q    <= '0;
      size_q   <= '0;
      ble_q    <= 1'b0;
      idx      <= '0;
      cnt      <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      done     <= 1'b1;
      error    <= 1'b0;
    end else if (soft_reset) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      done     <= 1'b1;
      error    <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            buf_q  <= input_data;
            size_q <= input_data_size;
            ble_q  <= ble_side;
            idx    <= '0;
            cnt    <= '0;
            if (input_data_size > 8'd128) begin
              error <= 1'b1;
              done  <= 1'b1;
            end else begin
              error <= 1'b0;
              done  <= 1'b0;
              if (!tx_busy) begin
                tx_data  <= first_byte;
                tx_start <= 1'b1;
                state    <= WAIT_HI;
              end else begin
                state <= SEND;
              end
            end
          end
        end
        SEND: begin
          if (timed_out) begin
            error <= 1'b1;
            done  <= 1'b1;
            state <= IDLE;
          end else if (!tx_busy) begin
            tx_data  <= cur_byte;
            tx_start <= 1'b1;
            cnt      <= '0;
            state    <= WAIT_HI;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_HI: begin
          if (timed_out) begin
            error <= 1'b1;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
            if (tx_busy)
              state <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (timed_out) begin
            error <= 1'b1;
            done  <= 1'b1;
            state <= IDLE;
          end else if (!tx_busy) begin
            if (idx == last_idx) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              idx   <= idx + 8'd1;
              cnt   <= '0;
              state <= SEND;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_command_serializer.sv
// tb/tb_uart_command_serializer.sv - scoreboard bench for uart_command_serializer
module tb_uart_command_serializer;

  logic          clk = 1'b0;
  logic          reset;
  logic          soft_reset;
  logic [1023:0] input_data;
  logic [7:0]    input_data_size;
  logic          ble_side;
  logic          start;
  logic          tx_busy;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          done;
  logic          error;

  uart_command_serializer #(.TIMEOUT(20)) dut (
    .clk             (clk),
    .reset           (reset),
    .soft_reset      (soft_reset),
    .input_data      (input_data),
    .input_data_size (input_data_size),
    .ble_side        (ble_side),
    .start           (start),
    .tx_busy         (tx_busy),
    .tx_data         (tx_data),
    .tx_start        (tx_start),
    .done            (done),
    .error           (error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  logic [7:0] exp_q[$];
  int strobes = 0;
  int cmd_strobes = 0;
  int busy_cnt = 0;
  int stuck_from = 0;
  bit prev_start = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // UART TX core model: busy for 10 cycles after each strobe, checks wire bytes against the scoreboard
  always @(negedge clk) begin
    if (reset) begin
      tx_busy    = 1'b0;
      busy_cnt   = 0;
      prev_start = 1'b0;
    end else begin
      if (tx_start) begin
        strobes++;
        cmd_strobes++;
        check("tx_start_gap", prev_start, 0);
        check("tx_start_while_busy", tx_busy, 0);
        check("queue_has_entry", exp_q.size() > 0, 1);
        if (exp_q.size() > 0)
          check("wire_byte", tx_data, exp_q.pop_front());
      end
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) tx_busy = 1'b0;
      end
      if (tx_start && !(stuck_from != 0 && cmd_strobes >= stuck_from)) begin
        tx_busy  = 1'b1;
        busy_cnt = 10;
      end
      prev_start = tx_start;
    end
  end

  task automatic load(input int size, input bit ble, input logic [7:0] base, input bit incr);
    input_data = '0;
    for (int k = 0; k < size && k < 128; k++)
      input_data[8*k +: 8] = incr ? base + 8'(k) : base;
    input_data_size = 8'(size);
    ble_side = ble;
  endtask

  task automatic push_cmd(input int size, input bit ble);
`ifdef UART_CMD_SER_LEN_PREFIX_EN
    exp_q.push_back(8'(size));
`endif
    for (int k = 0; k < size; k++)
      exp_q.push_back(input_data[8*k +: 8]);
    if (ble) exp_q.push_back(8'h0D);
    else begin
      exp_q.push_back(8'hBE);
      exp_q.push_back(8'hEF);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int i = 0;
    while (!done && i < limit) begin
      @(negedge clk);
      #1;
      i++;
    end
    check(tag, done, 1);
  endtask

  task automatic wait_strobes(input string tag, input int n, input int limit);
    int i = 0;
    while (cmd_strobes < n && i < limit) begin
      @(negedge clk);
      #1;
      i++;
    end
    check(tag, cmd_strobes >= n, 1);
  endtask

  int s0;
  int n_term;
  int pre;

  initial begin
`ifdef UART_CMD_SER_LEN_PREFIX_EN
    pre = 1;
`else
    pre = 0;
`endif
    reset = 1'b1;
    soft_reset = 1'b0;
    start = 1'b0;
    input_data = '0;
    input_data_size = '0;
    ble_side = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_done", done, 1);
    check("rst_error", error, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1: BLE side, three bytes
    load(3, 1'b1, 8'h41, 1'b1);
    push_cmd(3, 1'b1);
    cmd_strobes = 0;
    pulse_start();
    check("t1_first_strobe_latency", tx_start, 1);
    check("t1_done_low", done, 0);
    wait_done("t1_done", 200);
    check("t1_strobes", cmd_strobes, 4 + pre);
    check("t1_queue_empty", exp_q.size(), 0);
    check("t1_error", error, 0);
    check("t1_busy_fell", tx_busy, 0);

    // 2: host side, empty payload
    load(0, 1'b0, 8'h00, 1'b0);
    push_cmd(0, 1'b0);
    cmd_strobes = 0;
    pulse_start();
    wait_done("t2_done", 200);
    check("t2_strobes", cmd_strobes, 2 + pre);
    check("t2_queue_empty", exp_q.size(), 0);
    check("t2_error", error, 0);

    // 3: oversize request
    load(128, 1'b1, 8'h10, 1'b1);
    input_data_size = 8'd129;
    cmd_strobes = 0;
    pulse_start();
    check("t3_error", error, 1);
    check("t3_done", done, 1);
    repeat (5) @(negedge clk);
    #1;
    check("t3_no_strobe", cmd_strobes, 0);

    // 4: TX core stops responding after the second strobe
    load(3, 1'b1, 8'h11, 1'b1);
    push_cmd(3, 1'b1);
    stuck_from = 2;
    cmd_strobes = 0;
    pulse_start();
    wait_strobes("t4_second_strobe", 2, 200);
    begin
      int i = 0;
      while (!error && i < 40) begin
        @(negedge clk);
        #1;
        i++;
      end
      check("t4_abort_within_22", (error == 1'b1) && (i <= 22), 1);
    end
    check("t4_done", done, 1);
    repeat (30) @(negedge clk);
    #1;
    check("t4_no_more_strobes", cmd_strobes, 2);
    exp_q.delete();
    stuck_from = 0;
    load(1, 1'b0, 8'h77, 1'b0);
    push_cmd(1, 1'b0);
    cmd_strobes = 0;
    pulse_start();
    check("t4_error_cleared", error, 0);
    wait_done("t4_retry_done", 300);
    check("t4_retry_queue_empty", exp_q.size(), 0);
    check("t4_retry_error", error, 0);

    // 5: soft_reset while waiting for byte 1 to finish
    load(5, 1'b1, 8'h01, 1'b1);
    push_cmd(5, 1'b1);
    cmd_strobes = 0;
    pulse_start();
    wait_strobes("t5_second_strobe", 2 + pre, 200);
    repeat (4) @(negedge clk);
    soft_reset = 1'b1;
    @(negedge clk);
    soft_reset = 1'b0;
    #1;
    check("t5_done", done, 1);
    check("t5_error", error, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    load(1, 1'b1, 8'h55, 1'b0);
    push_cmd(1, 1'b1);
    cmd_strobes = 0;
    pulse_start();
    wait_done("t5_new_done", 300);
    check("t5_new_strobes", cmd_strobes, 2 + pre);
    check("t5_queue_empty", exp_q.size(), 0);

    // 6: full 128-byte payload, start pulsed mid-send
    load(128, 1'b0, 8'hFF, 1'b0);
    push_cmd(128, 1'b0);
    cmd_strobes = 0;
    pulse_start();
    wait_strobes("t6_mid_send", 50, 2000);
    load(5, 1'b1, 8'h00, 1'b0);
    pulse_start();
    wait_done("t6_done", 5000);
    n_term = 2;
    check("t6_strobes", cmd_strobes, 128 + n_term + pre);
    check("t6_queue_empty", exp_q.size(), 0);
    check("t6_error", error, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
